cnn_layer_seq: RTL
==================

// Module: cnn_layer_seq
// PURPOSE
//  Parametrised layer sequencer for the CNN datapath; generalises the fixed 6-state controller.
//  Walks NUM_LAYERS layers (load/conv/pool/FC) in order, or runs one software-selected layer.
//  Per layer: clears that layer's address counters, pulses MAC reset, runs until the layer's counter-done, drains the pipe.
//  Sits between the software register block and the ROM/RAM address counters, MAC and pool mux/demux.
// PARAMETERS
//  NUM_LAYERS  6       number of layers sequenced (index 0 = image load)
//  LAYER_W     3       width of layer index, >= clog2(NUM_LAYERS)
//  POOL_MASK   6'b010100  bit i = 1: layer i is pooling (drives pool path), else MAC path
//  DRAIN_CYC   2       cycles waited after cnt_done for MAC/pool pipeline to flush, >= 1
//  WDOG_W      16      watchdog counter width (used only with CNN_WDOG_EN)
// PORTS
//  clk         in   1           system clock
//  reset       in   1           synchronous, active-high
//  start       in   1           pulse: begin sequence (ignored unless IDLE or DONE)
//  single      in   1           sampled at start: 1 = run only sw_layer, 0 = run layers 0..NUM_LAYERS-1
//  sw_layer    in   LAYER_W     layer to run when single=1; sampled at start
//  abort       in   1           pulse: return to IDLE from any state
//  cnt_done    in   NUM_LAYERS  per-layer counter terminal flag (level)
//  cnt_clr     out  NUM_LAYERS  one-hot per-layer counter clear pulse
//  cnt_en      out  NUM_LAYERS  one-hot per-layer counter enable (read+write counters of that layer)
//  rmac        out  1           MAC accumulator reset pulse
//  layer_idx   out  LAYER_W     current layer, drives MAC/pool mux selects
//  pool_sel    out  1           POOL_MASK[layer_idx]
//  busy        out  1           high in any state except IDLE, DONE, ERR
//  layer_done  out  1           one-cycle pulse as each layer completes
//  done        out  1           level, high in DONE until next start/abort/reset
//  error       out  1           level, high in ERR (only reachable with CNN_WDOG_EN)
// BEHAVIOUR
//  Reset: state=IDLE, layer_idx=0, all outputs 0.
//  FSM: IDLE -> CLR -> MRST -> RUN -> DRAIN -> NEXT -> {CLR | DONE}.
//   IDLE/DONE: on start latch mode; layer_idx = single ? sw_layer : 0; go CLR next cycle.
//   CLR (1 cyc): cnt_clr[layer_idx]=1.   MRST (1 cyc): rmac=1 (skipped when pool_sel=1).
//   RUN: cnt_en[layer_idx]=1 until cnt_done[layer_idx]=1; cnt_en drops in the same cycle done is seen.
//   DRAIN: DRAIN_CYC cycles, all enables 0.   NEXT (1 cyc): layer_done=1.
//   NEXT: if single or layer_idx==NUM_LAYERS-1 -> DONE; else layer_idx+1 -> CLR.
//  Latency: start to first cnt_en = 3 cycles (2 for pool layers); cnt_done to layer_done = DRAIN_CYC+1.
//  cnt_done already high on entry to RUN: exactly one cnt_en cycle, then DRAIN (counters cleared in CLR, so legal only for zero-length layer).
//  sw_layer >= NUM_LAYERS at start: ignored, stays in IDLE/DONE.
//  start while busy: ignored. abort has priority over start and over every transition; reset over abort.
//  abort or reset mid-layer: next cycle IDLE, all enables/pulses 0, counters not cleared (next CLR does it).
//  cnt_done bits of non-current layers ignored. cnt_clr/cnt_en always one-hot or zero.
// CONFIGURATION
//  CNN_WDOG_EN defined: WDOG_W-bit counter clears on entry to RUN, counts in RUN; at all-ones -> ERR,
//   error=1, enables 0; ERR exits only on abort or reset.
//  Not defined: no counter, ERR unreachable, error tied 0.
// STRUCTURE
//  cnn_pkg: seq_state_t enum (IDLE,CLR,MRST,RUN,DRAIN,NEXT,DONE,ERR); default NUM_LAYERS, LAYER_W, POOL_MASK.
//  Sub-module cnn_wdog (counter + terminal flag), instantiated only under CNN_WDOG_EN.
//  Single always_ff for state/idx/drain count; outputs decoded combinationally from state and layer_idx.
// TESTING
//  Full run, defaults, cnt_done[i] asserted 10 cyc after cnt_en[i] rises -> 6 layer_done pulses, idx 0..5, done=1, rmac absent for layers 2,4.
//  single=1, sw_layer=3 -> only cnt_clr[3]/cnt_en[3] toggle, one layer_done, done=1, layer_idx=3.
//  abort 2 cycles into RUN of layer 2 -> IDLE next cycle, cnt_en=0, busy=0, done=0; restart runs from layer 0.
//  start while busy, and single with sw_layer=7 from IDLE -> no state change.
//  cnt_done[3] held high before RUN of layer 3 -> one cnt_en cycle, layer_done DRAIN_CYC+1 later.
//  CNN_WDOG_EN, WDOG_W=4, cnt_done never asserted -> error=1 after 15 RUN cycles; abort -> IDLE, error=0.

Source files
------------

// File: rtl/cnn_pkg.sv
// cnn_pkg
// Shared definitions for the CNN layer sequencer:
//   - default layer count, layer index width, pooling mask, drain length and
//     watchdog width used as parameter defaults by cnn_layer_seq
//   - sequencer state encodings as plain localparam constants, plus a
//     matching seq_state_t enum for readability in waveforms and debug code
package cnn_pkg;

  localparam int         CNN_NUM_LAYERS = 6;
  localparam int         CNN_LAYER_W    = 3;
  localparam logic [5:0] CNN_POOL_MASK  = 6'b010100;
  localparam int         CNN_DRAIN_CYC  = 2;
  localparam int         CNN_WDOG_W     = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLR   = 3'd1;
  localparam logic [2:0] ST_MRST  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;
  localparam logic [2:0] ST_NEXT  = 3'd5;
  localparam logic [2:0] ST_DONE  = 3'd6;
  localparam logic [2:0] ST_ERR   = 3'd7;

  typedef enum logic [2:0] {
    IDLE  = ST_IDLE,
    CLR   = ST_CLR,
    MRST  = ST_MRST,
    RUN   = ST_RUN,
    DRAIN = ST_DRAIN,
    NEXT  = ST_NEXT,
    DONE  = ST_DONE,
    ERR   = ST_ERR
  } seq_state_t;

endpackage

// File: rtl/cnn_wdog.sv
// cnn_wdog
// Watchdog for the RUN phase of the layer sequencer. The counter sits at zero
// whenever the sequencer is outside RUN, so it restarts on every entry to RUN,
// and advances once per RUN cycle.
// Ports:
//   clk     in   system clock
//   reset   in   synchronous, active-high
//   run     in   sequencer is in RUN this cycle
//   expire  out  high in the RUN cycle that takes the counter to all-ones
module cnn_wdog
  import cnn_pkg::*;
#(
  parameter int WDOG_W = CNN_WDOG_W
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic expire
);

  logic [WDOG_W-1:0] count;

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (run) begin
      count <= count + 1'b1;
    end else begin
      count <= '0;
    end
  end

  // Flag one cycle early so the sequencer leaves RUN exactly when the count
  // becomes all-ones, i.e. after 2**WDOG_W - 1 RUN cycles.
  assign expire = run && (count == {{(WDOG_W-1){1'b1}}, 1'b0});

endmodule

// File: rtl/cnn_layer_seq.sv
// cnn_layer_seq
// Layer sequencer for the CNN datapath. Walks layers 0..NUM_LAYERS-1 in order,
// or a single software-selected layer. For each layer it clears that layer's
// address counters, pulses the MAC accumulator reset (MAC layers only), enables
// the counters until their terminal flag, waits DRAIN_CYC cycles for the
// MAC/pool pipeline to flush and then signals layer completion.
// Optional feature: define CNN_WDOG_EN to add a RUN-phase watchdog that moves
// the sequencer to an error state; without it, error is tied low.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high
//   start       in   begin a sequence (honoured only in IDLE or DONE)
//   single      in   sampled at start: run only sw_layer
//   sw_layer    in   layer selected for single mode
//   abort       in   return to IDLE from any state
//   cnt_done    in   per-layer counter terminal flags
//   cnt_clr     out  one-hot per-layer counter clear pulse
//   cnt_en      out  one-hot per-layer counter enable
//   rmac        out  MAC accumulator reset pulse
//   layer_idx   out  current layer, drives MAC/pool mux selects
//   pool_sel    out  current layer is a pooling layer
//   busy        out  sequence in progress
//   layer_done  out  one-cycle pulse per finished layer
//   done        out  sequence finished, held until start/abort/reset
//   error       out  watchdog expired (CNN_WDOG_EN builds only)
module cnn_layer_seq
  import cnn_pkg::*;
#(
  parameter int                    NUM_LAYERS = CNN_NUM_LAYERS,
  parameter int                    LAYER_W    = CNN_LAYER_W,
  parameter logic [NUM_LAYERS-1:0] POOL_MASK  = CNN_POOL_MASK,
  parameter int                    DRAIN_CYC  = CNN_DRAIN_CYC,
  parameter int                    WDOG_W     = CNN_WDOG_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  single,
  input  logic [LAYER_W-1:0]    sw_layer,
  input  logic                  abort,
  input  logic [NUM_LAYERS-1:0] cnt_done,
  output logic [NUM_LAYERS-1:0] cnt_clr,
  output logic [NUM_LAYERS-1:0] cnt_en,
  output logic                  rmac,
  output logic [LAYER_W-1:0]    layer_idx,
  output logic                  pool_sel,
  output logic                  busy,
  output logic                  layer_done,
  output logic                  done,
  output logic                  error
);

  localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);

  logic [2:0]            state;
  logic                  single_mode;
  logic [DRAIN_W-1:0]    drain_cnt;
  logic [NUM_LAYERS-1:0] idx_onehot;
  logic                  cur_done;
  logic                  last_layer;
  logic                  start_ok;
  logic                  wdog_expire;

  assign idx_onehot = {{(NUM_LAYERS-1){1'b0}}, 1'b1} << layer_idx;
  // Only the current layer's terminal flag matters.
  assign cur_done   = |(cnt_done & idx_onehot);
  assign pool_sel   = |(POOL_MASK & idx_onehot);
  assign last_layer = (layer_idx == LAYER_W'(NUM_LAYERS - 1));
  // A single-layer request naming a layer that does not exist is dropped.
  assign start_ok   = !single || (int'(sw_layer) < NUM_LAYERS);

`ifdef CNN_WDOG_EN
  cnn_wdog #(
    .WDOG_W (WDOG_W)
  ) u_wdog (
    .clk    (clk),
    .reset  (reset),
    .run    (state == ST_RUN),
    .expire (wdog_expire)
  );
  assign error = (state == ST_ERR);
`else
  assign wdog_expire = 1'b0;
  assign error       = 1'b0;
`endif

  // Abort outranks every transition; counters are not cleared on abort
  // because the next CLR visit does it anyway.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      layer_idx   <= '0;
      single_mode <= 1'b0;
      drain_cnt   <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      layer_idx <= '0;
      drain_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start && start_ok) begin
            single_mode <= single;
            layer_idx   <= single ? sw_layer : '0;
            state       <= ST_CLR;
          end
        end
        ST_CLR:   state <= pool_sel ? ST_RUN : ST_MRST;
        ST_MRST:  state <= ST_RUN;
        ST_RUN: begin
          if (cur_done) begin
            drain_cnt <= DRAIN_W'(DRAIN_CYC - 1);
            state     <= ST_DRAIN;
          end else if (wdog_expire) begin
            state <= ST_ERR;
          end
        end
        ST_DRAIN: begin
          if (drain_cnt == '0) begin
            state <= ST_NEXT;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_NEXT: begin
          if (single_mode || last_layer) begin
            state <= ST_DONE;
          end else begin
            layer_idx <= layer_idx + 1'b1;
            state     <= ST_CLR;
          end
        end
        ST_ERR:   state <= ST_ERR;
        default:  state <= ST_IDLE;
      endcase
    end
  end

  // Outputs are decoded from the state register and the current layer index.
  always_comb begin
    cnt_clr    = (state == ST_CLR) ? idx_onehot : '0;
    cnt_en     = (state == ST_RUN) ? idx_onehot : '0;
    rmac       = (state == ST_MRST);
    layer_done = (state == ST_NEXT);
    done       = (state == ST_DONE);
    busy       = !((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERR));
  end

endmodule
